// File: rtl/rk_history_buffer.sv
// rk_history_buffer: multi-generation store for lane-packed CG vectors.
// Rows are captured through a ready/valid stream into a free bank. The bank
// is committed atomically, and any committed generation can be read by its
// relative age with one cycle of read latency.
// Optional feature macro: RK_HISTORY_ABORT_EN adds the capture_abort input.
module rk_history_buffer #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 8,
  parameter int MEMORY_HEIGHT = 1000,
  parameter int ADDRESS_WIDTH = $clog2(MEMORY_HEIGHT) + 1,
  parameter int HISTORY_DEPTH = 2,
  parameter int GEN_WIDTH     = $clog2(HISTORY_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 capture_start,
  input  logic [ADDRESS_WIDTH-1:0]             capture_len,
`ifdef RK_HISTORY_ABORT_EN
  input  logic                                 capture_abort,
`endif
  input  logic                                 wr_valid,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
  output logic                                 wr_ready,
  output logic                                 capture_done,
  output logic                                 cfg_err,
  input  logic                                 rd_en,
  input  logic [GEN_WIDTH-1:0]                 rd_gen,
  input  logic [ADDRESS_WIDTH-1:0]             rd_address,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
  output logic                                 rd_valid,
  output logic                                 rd_miss,
  output logic [GEN_WIDTH:0]                   gen_count,
  output logic                                 busy
);

  localparam int ROW_WIDTH  = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int TOTAL_ROWS = HISTORY_DEPTH * MEMORY_HEIGHT;
  localparam int MEM_AW     = $clog2(TOTAL_ROWS);
  localparam int GCW        = GEN_WIDTH + 1;

  localparam logic [GEN_WIDTH-1:0]     LAST_BANK = GEN_WIDTH'(HISTORY_DEPTH - 1);
  localparam logic [GCW-1:0]           DEPTH_CNT = GCW'(HISTORY_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] HEIGHT    = ADDRESS_WIDTH'(MEMORY_HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMMIT
  } state_t;

  state_t                   state;
  logic [GEN_WIDTH-1:0]     head;
  logic [GEN_WIDTH-1:0]     wbank;
  logic [GEN_WIDTH-1:0]     rbank;
  logic [ADDRESS_WIDTH-1:0] len;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [MEM_AW-1:0]        wr_idx;
  logic [MEM_AW-1:0]        rd_idx;
  logic                     len_bad;
  logic                     last_row;
  logic                     miss;
  logic                     in_flight;

  logic [ROW_WIDTH-1:0] mem [TOTAL_ROWS];

  // Write bank is the one after head, wrapping explicitly for any depth.
  always_comb begin
    wbank = (head == LAST_BANK) ? '0 : head + 1'b1;
  end

  // Read bank is head minus age, modulo depth without relying on powers of two.
  always_comb begin
    logic [GCW-1:0] wrapped;
    wrapped = {1'b0, head} + DEPTH_CNT - {1'b0, rd_gen};
    if (head >= rd_gen) begin
      rbank = head - rd_gen;
    end else begin
      rbank = wrapped[GEN_WIDTH-1:0];
    end
  end

  // Flat memory indices: bank-major, row-minor.
  always_comb begin
    wr_idx = MEM_AW'(wbank) * MEM_AW'(MEMORY_HEIGHT) + MEM_AW'(wr_ptr);
    rd_idx = MEM_AW'(rbank) * MEM_AW'(MEMORY_HEIGHT) + MEM_AW'(rd_address);
  end

  // Capture-length check and final-row detection.
  always_comb begin
    len_bad  = (capture_len == '0) || (capture_len > HEIGHT);
    last_row = wr_valid && (wr_ptr == len - 1'b1);
  end

  // A read misses on an absent generation, an out-of-range row, or the
  // oldest bank while it is being recycled for the capture in progress.
  always_comb begin
    in_flight = (state != S_IDLE);
    miss = ({1'b0, rd_gen} >= gen_count) ||
           (rd_address >= HEIGHT) ||
           (in_flight && (gen_count == DEPTH_CNT) && (rd_gen == LAST_BANK));
  end

  // Capture FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      head         <= LAST_BANK;
      gen_count    <= '0;
      len          <= '0;
      wr_ptr       <= '0;
      wr_ready     <= 1'b0;
      busy         <= 1'b0;
      capture_done <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      capture_done <= 1'b0;
      cfg_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (capture_start) begin
            if (len_bad) begin
              cfg_err <= 1'b1;
            end else begin
              len      <= capture_len;
              wr_ptr   <= '0;
              state    <= S_CAPTURE;
              wr_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (wr_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
`ifdef RK_HISTORY_ABORT_EN
          // Abort wins over a same-cycle final row: the row lands but head stays.
          if (capture_abort) begin
            state    <= S_IDLE;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
          end else
`endif
          if (last_row) begin
            state        <= S_COMMIT;
            wr_ready     <= 1'b0;
            capture_done <= 1'b1;
          end
        end
        S_COMMIT: begin
          head <= wbank;
          if (gen_count != DEPTH_CNT) begin
            gen_count <= gen_count + 1'b1;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          wr_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Row storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if ((state == S_CAPTURE) && wr_valid) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered read port; rd_data holds when no request is made.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_miss  <= rd_en && miss;
      if (rd_en) begin
        rd_data <= miss ? '0 : mem[rd_idx];
      end
    end
  end

endmodule
